// File: rtl/gfx_pkg.sv
// Shared types and register map for the graphics write FIFO.
package gfx_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_cmd_t;

  localparam logic DATA_OFS = 1'b0;
  localparam logic CTRL_OFS = 1'b1;

  localparam int STAT_FULL  = 16;
  localparam int STAT_EMPTY = 17;
  localparam int CTRL_FLUSH = 0;

endpackage

// File: rtl/graphics_write_fifo_sync_fifo.sv
// Synchronous FIFO with registered occupancy count, flush and fall-through head read.
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // Flush wins over everything, so a same-cycle pop is simply discarded.
  assign doPush = push_i && !full_o && !flush_i;
  assign doPop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/graphics_write_fifo.sv
// CPU-side bus decode for buffered pixel writes, replayed to the plot consumer.
module graphics_write_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        Graphics_Select,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic [3:0]  Byte_Enable,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        DTAck,
  output logic [7:0]  Plot_X,
  output logic [6:0]  Plot_Y,
  output logic [2:0]  Plot_Colour,
  output logic        Plot_Valid,
  input  logic        Plot_Ready
);

  logic             access;
  logic             dataWr;
  logic             ctrlWr;
  logic             statusRd;
  logic             fullBe;
  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             accepted_q, accepted_d;
  plot_cmd_t        cmdIn;
  plot_cmd_t        cmdHead;
  logic [31:0]      statusWord;
  logic             unusedBits;

  assign unusedBits = ^{Address[31:3], Address[1:0], DataIn[31:18]};

  assign access   = Graphics_Select && !AS_L;
  assign dataWr   = access && !WE_L && (Address[2] == DATA_OFS);
  assign ctrlWr   = access && !WE_L && (Address[2] == CTRL_OFS);
  assign statusRd = access && WE_L && (Address[2] == CTRL_OFS);
  assign fullBe   = (Byte_Enable == 4'hF);

  assign cmdIn.x      = DataIn[7:0];
  assign cmdIn.y      = DataIn[14:8];
  assign cmdIn.colour = DataIn[17:15];

  assign push  = dataWr && fullBe && !accepted_q && !full;
  assign pop   = Plot_Valid && Plot_Ready;
  assign flush = ctrlWr && DataIn[CTRL_FLUSH];

  // Only a still-pending full-width DATA write can be stalled; partial writes ack and drop.
  assign DTAck = !(dataWr && fullBe && !accepted_q && full);

  always_comb begin
    accepted_d = accepted_q;
    if (AS_L)      accepted_d = 1'b0;
    else if (push) accepted_d = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) accepted_q <= 1'b0;
    else         accepted_q <= accepted_d;
  end

  always_comb begin
    statusWord             = '0;
    statusWord[CNT_W-1:0]  = count;
    statusWord[STAT_FULL]  = full;
    statusWord[STAT_EMPTY] = empty;
  end

  assign DataOut = statusRd ? statusWord : 32'h0;

  sync_fifo #(
    .WIDTH ($bits(plot_cmd_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset_H),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (cmdIn),
    .rdata_o (cmdHead),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign Plot_Valid  = !empty;
  assign Plot_X      = cmdHead.x;
  assign Plot_Y      = cmdHead.y;
  assign Plot_Colour = cmdHead.colour;

endmodule

// File: tb/tb_graphics_write_fifo.sv
// Directed self-checking bench for graphics_write_fifo with hand-computed expectations.
module tb_graphics_write_fifo;

  logic        Clock;
  logic        Reset_H;
  logic        Graphics_Select;
  logic        AS_L;
  logic        WE_L;
  logic [3:0]  Byte_Enable;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        DTAck;
  logic [7:0]  Plot_X;
  logic [6:0]  Plot_Y;
  logic [2:0]  Plot_Colour;
  logic        Plot_Valid;
  logic        Plot_Ready;

  int errors = 0;
  int checks = 0;

  graphics_write_fifo dut (
    .Clock           (Clock),
    .Reset_H         (Reset_H),
    .Graphics_Select (Graphics_Select),
    .AS_L            (AS_L),
    .WE_L            (WE_L),
    .Byte_Enable     (Byte_Enable),
    .Address         (Address),
    .DataIn          (DataIn),
    .DataOut         (DataOut),
    .DTAck           (DTAck),
    .Plot_X          (Plot_X),
    .Plot_Y          (Plot_Y),
    .Plot_Colour     (Plot_Colour),
    .Plot_Valid      (Plot_Valid),
    .Plot_Ready      (Plot_Ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic asL, input logic weL,
                               input logic [3:0] be, input logic [31:0] addr, input logic [31:0] data);
    Graphics_Select = sel;
    AS_L            = asL;
    WE_L            = weL;
    Byte_Enable     = be;
    Address         = addr;
    DataIn          = data;
    #1;
  endtask

  task automatic busIdle();
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic writeData(input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, d);
    tick();
    busIdle();
    tick();
  endtask

  task automatic writeCtrl(input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h4, d);
    tick();
    busIdle();
    tick();
  endtask

  task automatic checkStatus(input string tag, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 32'h4, 32'h0);
    checkOutput(tag, DataOut, expected);
    busIdle();
  endtask

  function automatic logic [31:0] packCmd(input int x, input int y, input int c);
    return 32'(((c & 7) << 15) | ((y & 127) << 8) | (x & 255));
  endfunction

  initial begin
    Reset_H    = 1'b1;
    Plot_Ready = 1'b0;
    busIdle();
    tick();
    tick();
    Reset_H = 1'b0;
    #1;
    checkOutput("rst_valid", Plot_Valid, 0);
    checkOutput("rst_dtack", DTAck, 1);
    checkOutput("rst_dataout", DataOut, 0);
    checkStatus("rst_status", 32'h0002_0000);

    // First write and fall-through head
    writeData(32'h0001_2A05);
    checkOutput("w1_valid", Plot_Valid, 1);
    checkOutput("w1_x", Plot_X, 5);
    checkOutput("w1_y", Plot_Y, 32'h2A);
    checkOutput("w1_colour", Plot_Colour, 2);
    checkStatus("w1_status", 32'h0000_0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0);
    checkOutput("data_read_zero", DataOut, 0);
    busIdle();
    writeCtrl(32'h1);

    // Long strobe: one push only
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, packCmd(9, 9, 1));
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_dtack%0d", i), DTAck, 1);
      tick();
    end
    busIdle();
    tick();
    checkStatus("hold_status", 32'h0000_0001);
    writeCtrl(32'h1);

    // Partial byte enables ack and drop
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 32'h0, packCmd(1, 1, 1));
    checkOutput("partial_dtack", DTAck, 1);
    tick();
    busIdle();
    tick();
    checkStatus("partial_status", 32'h0002_0000);

    // Fill, stall, release by one pop
    for (int i = 0; i < 16; i++) writeData(packCmd(i + 16, i, i));
    checkStatus("full_status", 32'h0001_0010);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, packCmd(100, 5, 3));
    checkOutput("stall_dtack0", DTAck, 0);
    tick();
    checkOutput("stall_dtack1", DTAck, 0);
    checkOutput("stall_head_stable", Plot_X, 16);
    Plot_Ready = 1'b1;
    #1;
    checkOutput("stall_dtack_ready", DTAck, 0);
    tick();
    Plot_Ready = 1'b0;
    #1;
    checkOutput("stall_release", DTAck, 1);
    checkOutput("stall_head_next", Plot_X, 17);
    tick();
    busIdle();
    tick();
    checkStatus("refill_status", 32'h0001_0010);
    writeCtrl(32'h1);

    // Three pops in order
    writeData(packCmd(7, 8, 1));
    writeData(packCmd(159, 119, 7));
    writeData(packCmd(0, 1, 4));
    Plot_Ready = 1'b1;
    #1;
    checkOutput("pop0_x", Plot_X, 7);
    checkOutput("pop0_y", Plot_Y, 8);
    checkOutput("pop0_c", Plot_Colour, 1);
    tick();
    checkOutput("pop1_x", Plot_X, 159);
    checkOutput("pop1_y", Plot_Y, 119);
    checkOutput("pop1_c", Plot_Colour, 7);
    tick();
    checkOutput("pop2_valid", Plot_Valid, 1);
    checkOutput("pop2_x", Plot_X, 0);
    checkOutput("pop2_y", Plot_Y, 1);
    checkOutput("pop2_c", Plot_Colour, 4);
    tick();
    checkOutput("pop_done_valid", Plot_Valid, 0);
    Plot_Ready = 1'b0;
    checkStatus("pop_done_status", 32'h0002_0000);

    // Simultaneous push/pop at count 1 across pointer wrap
    writeData(packCmd(0, 0, 0));
    for (int k = 1; k <= 40; k++) begin
      Plot_Ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, packCmd((k * 3) % 160, k, k % 8));
      tick();
      Plot_Ready = 1'b0;
      busIdle();
      checkOutput($sformatf("wrap_x%0d", k), Plot_X, (k * 3) % 160);
      checkOutput($sformatf("wrap_y%0d", k), Plot_Y, k);
      checkOutput($sformatf("wrap_c%0d", k), Plot_Colour, k % 8);
      checkStatus($sformatf("wrap_status%0d", k), 32'h0000_0001);
      tick();
    end
    writeCtrl(32'h1);

    // Flush with a same-cycle pop
    for (int i = 0; i < 10; i++) writeData(packCmd(i, i, i));
    checkStatus("pre_flush_status", 32'h0000_000A);
    Plot_Ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h4, 32'h1);
    checkOutput("flush_dtack", DTAck, 1);
    tick();
    Plot_Ready = 1'b0;
    busIdle();
    checkOutput("flush_valid", Plot_Valid, 0);
    checkStatus("flush_status", 32'h0002_0000);
    tick();

    // Reset during a full stall
    for (int i = 0; i < 16; i++) writeData(packCmd(i, 0, 0));
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 32'h0, packCmd(50, 50, 5));
    checkOutput("rst_stall_dtack", DTAck, 0);
    Reset_H = 1'b1;
    tick();
    Reset_H = 1'b0;
    #1;
    checkOutput("rst_stall_release", DTAck, 1);
    checkOutput("rst_stall_valid", Plot_Valid, 0);
    busIdle();
    tick();
    checkStatus("rst_stall_status", 32'h0002_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
